// File: rtl/tilelink_cdc_pkg.sv
// rtl/tilelink_cdc_pkg.sv - shared TileLink constants, widths and tag-table entry type
package tilelink_cdc_pkg;

   localparam int TL_ADDR_WIDTH   = 32;
   localparam int TL_DATA_WIDTH   = 32;
   localparam int TL_SIZE_WIDTH   = 3;
   localparam int TL_OPCODE_WIDTH = 3;
   localparam int TL_PARAM_WIDTH  = 3;
   localparam int TL_SINK_WIDTH   = 1;
   localparam int TL_SRC_WIDTH    = 2;

   // Host index is sized for the largest supported host count (4); the
   // original source is stored zero-extended so one entry type fits all hosts.
   localparam int TL_HOST_IDX_WIDTH = 2;
   localparam int TL_MAX_HOST_SRC_WIDTH = 8;

   localparam logic [2:0] TL_OP_PUT_FULL_DATA    = 3'd0;
   localparam logic [2:0] TL_OP_PUT_PARTIAL_DATA = 3'd1;
   localparam logic [2:0] TL_OP_GET              = 3'd4;
   localparam logic [2:0] TL_OP_ACCESS_ACK       = 3'd0;
   localparam logic [2:0] TL_OP_ACCESS_ACK_DATA  = 3'd1;

   typedef struct packed {
      logic                             valid;
      logic [TL_HOST_IDX_WIDTH-1:0]     host_idx;
      logic [TL_MAX_HOST_SRC_WIDTH-1:0] orig_src;
   } tag_entry_t;

endpackage

// File: rtl/tilelink_rr_arbiter.sv
// rtl/tilelink_rr_arbiter.sv - N-way round-robin arbiter with pointer and grant lock
module tilelink_rr_arbiter
   import tilelink_cdc_pkg::*;
#(
   parameter int N = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N-1:0]                 req,
   input  logic                         lock,
   input  logic [TL_HOST_IDX_WIDTH-1:0] lock_idx,
   input  logic                         advance,
   output logic                         gnt_valid,
   output logic [TL_HOST_IDX_WIDTH-1:0] gnt_idx
);

   logic [TL_HOST_IDX_WIDTH-1:0] rr_ptr;
   logic [2*N-1:0]               req2;

   assign req2 = {req, req};

   // Scan the doubled request vector downward so the last hit wins,
   // leaving the first requester at or after rr_ptr.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      if (lock) begin
         gnt_valid = 1'b1;
         gnt_idx   = lock_idx;
      end else begin
         for (int i = 2*N-1; i >= 0; i--) begin
            if (req2[i] && (i >= int'(rr_ptr)) && (i < int'(rr_ptr) + N)) begin
               gnt_valid = 1'b1;
               gnt_idx   = TL_HOST_IDX_WIDTH'(i % N);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= (int'(gnt_idx) == N-1) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/tilelink_cdc_arbiter.sv
// rtl/tilelink_cdc_arbiter.sv - shares one adapter A/D port among N hosts with source-tag remapping
module tilelink_cdc_arbiter
   import tilelink_cdc_pkg::*;
#(
   parameter int N_HOSTS        = 2,
   parameter int ADDR_WIDTH     = TL_ADDR_WIDTH,
   parameter int DATA_WIDTH     = TL_DATA_WIDTH,
   parameter int MASK_WIDTH     = DATA_WIDTH/8,
   parameter int SIZE_WIDTH     = TL_SIZE_WIDTH,
   parameter int OPCODE_WIDTH   = TL_OPCODE_WIDTH,
   parameter int PARAM_WIDTH    = TL_PARAM_WIDTH,
   parameter int SINK_WIDTH     = TL_SINK_WIDTH,
   parameter int SRC_WIDTH      = TL_SRC_WIDTH,
   parameter int HOST_SRC_WIDTH = 1
) (
   input  logic                              clk_in,
   input  logic                              reset_n,
   input  logic [N_HOSTS-1:0]                host_a_valid,
   output logic [N_HOSTS-1:0]                host_a_ready,
   input  logic [N_HOSTS*OPCODE_WIDTH-1:0]   host_a_opcode,
   input  logic [N_HOSTS*PARAM_WIDTH-1:0]    host_a_param,
   input  logic [N_HOSTS*SIZE_WIDTH-1:0]     host_a_size,
   input  logic [N_HOSTS*HOST_SRC_WIDTH-1:0] host_a_source,
   input  logic [N_HOSTS*ADDR_WIDTH-1:0]     host_a_address,
   input  logic [N_HOSTS*MASK_WIDTH-1:0]     host_a_mask,
   input  logic [N_HOSTS*DATA_WIDTH-1:0]     host_a_data,
   output logic                              a_valid_out,
   input  logic                              a_ready_out,
   output logic [OPCODE_WIDTH-1:0]           a_opcode_out,
   output logic [PARAM_WIDTH-1:0]            a_param_out,
   output logic [SIZE_WIDTH-1:0]             a_size_out,
   output logic [SRC_WIDTH-1:0]              a_source_out,
   output logic [ADDR_WIDTH-1:0]             a_address_out,
   output logic [MASK_WIDTH-1:0]             a_mask_out,
   output logic [DATA_WIDTH-1:0]             a_data_out,
   input  logic                              d_valid_in,
   output logic                              d_ready_in,
   input  logic [OPCODE_WIDTH-1:0]           d_opcode_in,
   input  logic [PARAM_WIDTH-1:0]            d_param_in,
   input  logic [SIZE_WIDTH-1:0]             d_size_in,
   input  logic [SINK_WIDTH-1:0]             d_sink_in,
   input  logic [SRC_WIDTH-1:0]              d_source_in,
   input  logic [DATA_WIDTH-1:0]             d_data_in,
   input  logic                              d_error_in,
   output logic [N_HOSTS-1:0]                host_d_valid,
   input  logic [N_HOSTS-1:0]                host_d_ready,
   output logic [OPCODE_WIDTH-1:0]           host_d_opcode,
   output logic [PARAM_WIDTH-1:0]            host_d_param,
   output logic [SIZE_WIDTH-1:0]             host_d_size,
   output logic [SINK_WIDTH-1:0]             host_d_sink,
   output logic [HOST_SRC_WIDTH-1:0]         host_d_source,
   output logic [DATA_WIDTH-1:0]             host_d_data,
   output logic                              host_d_error,
   output logic [SRC_WIDTH:0]                outstanding,
   output logic                              err_unknown_tag
);

   localparam int NUM_TAGS = 2**SRC_WIDTH;
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;
   localparam logic [SRC_WIDTH:0] CNT_ONE = 1;

   logic [0:0]                   state;
   logic [TL_HOST_IDX_WIDTH-1:0] lock_idx;
   logic [SRC_WIDTH-1:0]         lock_tag;
   tag_entry_t                   tag_table [NUM_TAGS];

   logic                         free_valid;
   logic [SRC_WIDTH-1:0]         free_tag;
   logic [SRC_WIDTH-1:0]         cur_tag;
   logic [N_HOSTS-1:0]           arb_req;
   logic                         gnt_valid;
   logic [TL_HOST_IDX_WIDTH-1:0] gnt_idx;
   logic [HOST_SRC_WIDTH-1:0]    sel_src;
   logic                         a_fire;
   tag_entry_t                   d_entry;
   logic                         sel_d_ready;
   logic                         d_fire;

   // Free tag comes from registered state only, so a tag freed this cycle
   // is never handed out in the same cycle.
   always_comb begin
      free_valid = 1'b0;
      free_tag   = '0;
      for (int t = NUM_TAGS-1; t >= 0; t--) begin
         if (!tag_table[t].valid) begin
            free_valid = 1'b1;
            free_tag   = SRC_WIDTH'(t);
         end
      end
   end

   assign arb_req = (state == ST_IDLE) ? (host_a_valid & {N_HOSTS{free_valid}}) : '0;
   assign cur_tag = (state == ST_LOCKED) ? lock_tag : free_tag;

   tilelink_rr_arbiter #(.N(N_HOSTS)) u_rr_arbiter (
      .clk       (clk_in),
      .rst_n     (reset_n),
      .req       (arb_req),
      .lock      (state == ST_LOCKED),
      .lock_idx  (lock_idx),
      .advance   (a_fire),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      a_opcode_out  = '0;
      a_param_out   = '0;
      a_size_out    = '0;
      a_address_out = '0;
      a_mask_out    = '0;
      a_data_out    = '0;
      sel_src       = '0;
      for (int i = 0; i < N_HOSTS; i++) begin
         if (gnt_idx == TL_HOST_IDX_WIDTH'(i)) begin
            a_opcode_out  = host_a_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH];
            a_param_out   = host_a_param[i*PARAM_WIDTH +: PARAM_WIDTH];
            a_size_out    = host_a_size[i*SIZE_WIDTH +: SIZE_WIDTH];
            a_address_out = host_a_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            a_mask_out    = host_a_mask[i*MASK_WIDTH +: MASK_WIDTH];
            a_data_out    = host_a_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_src       = host_a_source[i*HOST_SRC_WIDTH +: HOST_SRC_WIDTH];
         end
      end
   end

   assign a_valid_out  = reset_n && gnt_valid;
   assign a_source_out = cur_tag;
   assign a_fire       = a_valid_out && a_ready_out;

   always_comb begin
      host_a_ready = '0;
      for (int i = 0; i < N_HOSTS; i++) begin
         host_a_ready[i] = a_fire && (gnt_idx == TL_HOST_IDX_WIDTH'(i));
      end
   end

   // D path: the tag entry steers the beat back to its host; unknown tags are sunk.
   assign d_entry = tag_table[d_source_in];

   always_comb begin
      host_d_valid = '0;
      sel_d_ready  = 1'b0;
      for (int i = 0; i < N_HOSTS; i++) begin
         if (d_entry.host_idx == TL_HOST_IDX_WIDTH'(i)) begin
            host_d_valid[i] = reset_n && d_valid_in && d_entry.valid;
            sel_d_ready     = host_d_ready[i];
         end
      end
   end

   assign d_ready_in      = reset_n && (d_entry.valid ? sel_d_ready : 1'b1);
   assign d_fire          = d_valid_in && d_ready_in && d_entry.valid;
   assign err_unknown_tag = reset_n && d_valid_in && !d_entry.valid;

   assign host_d_opcode = d_opcode_in;
   assign host_d_param  = d_param_in;
   assign host_d_size   = d_size_in;
   assign host_d_sink   = d_sink_in;
   assign host_d_data   = d_data_in;
   assign host_d_error  = d_error_in;
   assign host_d_source = HOST_SRC_WIDTH'(d_entry.orig_src);

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         lock_idx    <= '0;
         lock_tag    <= '0;
         outstanding <= '0;
         for (int t = 0; t < NUM_TAGS; t++) begin
            tag_table[t] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (a_valid_out && !a_ready_out) begin
                  state    <= ST_LOCKED;
                  lock_idx <= gnt_idx;
                  lock_tag <= free_tag;
               end
            end
            default: begin
               if (a_ready_out) begin
                  state <= ST_IDLE;
               end
            end
         endcase

         // Freed and allocated tags always differ, so both writes can land.
         if (d_fire) begin
            tag_table[d_source_in].valid <= 1'b0;
         end
         if (a_fire) begin
            tag_table[cur_tag] <= '{valid: 1'b1, host_idx: gnt_idx,
                                    orig_src: TL_MAX_HOST_SRC_WIDTH'(sel_src)};
         end

         if (a_fire && !d_fire) begin
            outstanding <= outstanding + CNT_ONE;
         end else if (!a_fire && d_fire) begin
            outstanding <= outstanding - CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_tilelink_cdc_arbiter.sv
// tb/tb_tilelink_cdc_arbiter.sv - directed self-checking bench for tilelink_cdc_arbiter
module tb_tilelink_cdc_arbiter;
   import tilelink_cdc_pkg::*;

   localparam int N = 2;

   logic          clk_in = 1'b0;
   logic          reset_n;
   logic [N-1:0]  host_a_valid, host_a_ready;
   logic [N*3-1:0]  host_a_opcode, host_a_param, host_a_size;
   logic [N-1:0]    host_a_source;
   logic [N*32-1:0] host_a_address, host_a_data;
   logic [N*4-1:0]  host_a_mask;
   logic          a_valid_out, a_ready_out;
   logic [2:0]    a_opcode_out, a_param_out, a_size_out;
   logic [1:0]    a_source_out;
   logic [31:0]   a_address_out, a_data_out;
   logic [3:0]    a_mask_out;
   logic          d_valid_in, d_ready_in;
   logic [2:0]    d_opcode_in, d_param_in, d_size_in;
   logic [0:0]    d_sink_in;
   logic [1:0]    d_source_in;
   logic [31:0]   d_data_in;
   logic          d_error_in;
   logic [N-1:0]  host_d_valid, host_d_ready;
   logic [2:0]    host_d_opcode, host_d_param, host_d_size;
   logic [0:0]    host_d_sink;
   logic [0:0]    host_d_source;
   logic [31:0]   host_d_data;
   logic          host_d_error;
   logic [2:0]    outstanding;
   logic          err_unknown_tag;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   tilelink_cdc_arbiter #(.N_HOSTS(N)) dut (
      .clk_in(clk_in), .reset_n(reset_n),
      .host_a_valid(host_a_valid), .host_a_ready(host_a_ready),
      .host_a_opcode(host_a_opcode), .host_a_param(host_a_param), .host_a_size(host_a_size),
      .host_a_source(host_a_source), .host_a_address(host_a_address),
      .host_a_mask(host_a_mask), .host_a_data(host_a_data),
      .a_valid_out(a_valid_out), .a_ready_out(a_ready_out),
      .a_opcode_out(a_opcode_out), .a_param_out(a_param_out), .a_size_out(a_size_out),
      .a_source_out(a_source_out), .a_address_out(a_address_out),
      .a_mask_out(a_mask_out), .a_data_out(a_data_out),
      .d_valid_in(d_valid_in), .d_ready_in(d_ready_in),
      .d_opcode_in(d_opcode_in), .d_param_in(d_param_in), .d_size_in(d_size_in),
      .d_sink_in(d_sink_in), .d_source_in(d_source_in), .d_data_in(d_data_in),
      .d_error_in(d_error_in),
      .host_d_valid(host_d_valid), .host_d_ready(host_d_ready),
      .host_d_opcode(host_d_opcode), .host_d_param(host_d_param), .host_d_size(host_d_size),
      .host_d_sink(host_d_sink), .host_d_source(host_d_source), .host_d_data(host_d_data),
      .host_d_error(host_d_error),
      .outstanding(outstanding), .err_unknown_tag(err_unknown_tag)
   );

   task automatic set_host(input int h, input logic [2:0] op, input logic src, input logic [31:0] addr);
      host_a_valid[h]             = 1'b1;
      host_a_opcode[h*3 +: 3]     = op;
      host_a_source[h]            = src;
      host_a_address[h*32 +: 32]  = addr;
      host_a_data[h*32 +: 32]     = addr ^ 32'h5A5A_0000;
      host_a_mask[h*4 +: 4]       = 4'hF;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      host_a_valid = '0; host_a_opcode = '0; host_a_param = '0; host_a_size = '0;
      host_a_source = '0; host_a_address = '0; host_a_mask = '0; host_a_data = '0;
      a_ready_out = 1'b0;
      d_valid_in = 1'b0; d_opcode_in = '0; d_param_in = '0; d_size_in = '0;
      d_sink_in = '0; d_source_in = '0; d_data_in = '0; d_error_in = 1'b0;
      host_d_ready = '0;
      @(negedge clk_in);
      @(negedge clk_in);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      host_a_valid = 2'b11;
      d_valid_in = 1'b1;
      #1;
      checks++; if (a_valid_out !== 1'b0) begin errors++; $display("FAIL rst_a_valid: got %0b want 0", a_valid_out); end
      checks++; if (host_a_ready !== 2'b00) begin errors++; $display("FAIL rst_host_a_ready: got %b want 00", host_a_ready); end
      checks++; if (d_ready_in !== 1'b0) begin errors++; $display("FAIL rst_d_ready: got %0b want 0", d_ready_in); end
      checks++; if (err_unknown_tag !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", err_unknown_tag); end
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
      do_reset();
   endtask

   task automatic test_single_get();
      do_reset();
      set_host(0, TL_OP_GET, 1'b1, 32'h0000_1000);
      a_ready_out = 1'b1;
      #1;
      checks++; if (a_valid_out !== 1'b1) begin errors++; $display("FAIL get_a_valid: got %0b want 1", a_valid_out); end
      checks++; if (a_source_out !== 2'd0) begin errors++; $display("FAIL get_tag: got %0d want 0", a_source_out); end
      checks++; if (a_opcode_out !== 3'd4) begin errors++; $display("FAIL get_opcode: got %0d want 4", a_opcode_out); end
      checks++; if (a_address_out !== 32'h0000_1000) begin errors++; $display("FAIL get_addr: got %h want 00001000", a_address_out); end
      checks++; if (host_a_ready !== 2'b01) begin errors++; $display("FAIL get_host_ready: got %b want 01", host_a_ready); end
      @(negedge clk_in);
      host_a_valid = '0;
      #1;
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL get_outstanding1: got %0d want 1", outstanding); end
      d_valid_in = 1'b1; d_source_in = 2'd0; d_opcode_in = TL_OP_ACCESS_ACK_DATA;
      d_data_in = 32'hCAFE_F00D; host_d_ready = 2'b01;
      #1;
      checks++; if (host_d_valid !== 2'b01) begin errors++; $display("FAIL get_d_valid: got %b want 01", host_d_valid); end
      checks++; if (host_d_source !== 1'b1) begin errors++; $display("FAIL get_d_source: got %0d want 1", host_d_source); end
      checks++; if (host_d_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL get_d_data: got %h want cafef00d", host_d_data); end
      checks++; if (d_ready_in !== 1'b1) begin errors++; $display("FAIL get_d_ready: got %0b want 1", d_ready_in); end
      @(negedge clk_in);
      d_valid_in = 1'b0;
      #1;
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL get_outstanding0: got %0d want 0", outstanding); end
   endtask

   task automatic test_round_robin();
      do_reset();
      set_host(0, TL_OP_GET, 1'b0, 32'h0000_0100);
      set_host(1, TL_OP_GET, 1'b1, 32'h0000_0200);
      a_ready_out = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (host_a_ready !== ((k % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d: got %b", k, host_a_ready); end
         checks++; if (a_source_out !== 2'(k)) begin errors++; $display("FAIL rr_tag%0d: got %0d want %0d", k, a_source_out, k); end
         checks++; if (a_address_out !== ((k % 2) ? 32'h200 : 32'h100)) begin errors++; $display("FAIL rr_addr%0d: got %h", k, a_address_out); end
         @(negedge clk_in);
      end
      #1;
      checks++; if (a_valid_out !== 1'b0) begin errors++; $display("FAIL rr_full_stall: got %0b want 0", a_valid_out); end
      checks++; if (host_a_ready !== 2'b00) begin errors++; $display("FAIL rr_full_ready: got %b want 00", host_a_ready); end
      checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL rr_outstanding4: got %0d want 4", outstanding); end
      d_valid_in = 1'b1; d_source_in = 2'd1; host_d_ready = 2'b11;
      #1;
      checks++; if (host_d_valid !== 2'b10) begin errors++; $display("FAIL rr_d_valid: got %b want 10", host_d_valid); end
      checks++; if (host_d_source !== 1'b1) begin errors++; $display("FAIL rr_d_source: got %0d want 1", host_d_source); end
      checks++; if (a_valid_out !== 1'b0) begin errors++; $display("FAIL rr_no_bypass: got %0b want 0", a_valid_out); end
      @(negedge clk_in);
      d_valid_in = 1'b0;
      #1;
      checks++; if (a_valid_out !== 1'b1) begin errors++; $display("FAIL rr_resume_valid: got %0b want 1", a_valid_out); end
      checks++; if (a_source_out !== 2'd1) begin errors++; $display("FAIL rr_resume_tag: got %0d want 1", a_source_out); end
      checks++; if (host_a_ready !== 2'b01) begin errors++; $display("FAIL rr_resume_grant: got %b want 01", host_a_ready); end
      @(negedge clk_in);
      host_a_valid = '0;
      #1;
      checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL rr_outstanding_end: got %0d want 4", outstanding); end
   endtask

   task automatic test_lock();
      do_reset();
      set_host(1, TL_OP_PUT_FULL_DATA, 1'b1, 32'h0000_0300);
      a_ready_out = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (a_valid_out !== 1'b1) begin errors++; $display("FAIL lock_valid%0d: got %0b want 1", k, a_valid_out); end
         checks++; if (a_address_out !== 32'h300) begin errors++; $display("FAIL lock_addr%0d: got %h want 300", k, a_address_out); end
         checks++; if (a_source_out !== 2'd0) begin errors++; $display("FAIL lock_tag%0d: got %0d want 0", k, a_source_out); end
         checks++; if (host_a_ready !== 2'b00) begin errors++; $display("FAIL lock_ready%0d: got %b want 00", k, host_a_ready); end
         @(negedge clk_in);
         set_host(0, TL_OP_GET, 1'b0, 32'h0000_0100);
      end
      a_ready_out = 1'b1;
      #1;
      checks++; if (host_a_ready !== 2'b10) begin errors++; $display("FAIL lock_release_ready: got %b want 10", host_a_ready); end
      checks++; if (a_address_out !== 32'h300) begin errors++; $display("FAIL lock_release_addr: got %h want 300", a_address_out); end
      @(negedge clk_in);
      host_a_valid[1] = 1'b0;
      #1;
      checks++; if (host_a_ready !== 2'b01) begin errors++; $display("FAIL lock_next_grant: got %b want 01", host_a_ready); end
      checks++; if (a_source_out !== 2'd1) begin errors++; $display("FAIL lock_next_tag: got %0d want 1", a_source_out); end
      host_a_valid = '0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      set_host(0, TL_OP_GET, 1'b0, 32'h0000_0400);
      a_ready_out = 1'b1;
      repeat (3) @(negedge clk_in);
      #1;
      checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL sim_outstanding3: got %0d want 3", outstanding); end
      d_valid_in = 1'b1; d_source_in = 2'd2; host_d_ready = 2'b01;
      #1;
      checks++; if (a_source_out !== 2'd3) begin errors++; $display("FAIL sim_alloc_tag: got %0d want 3", a_source_out); end
      checks++; if (host_a_ready !== 2'b01) begin errors++; $display("FAIL sim_a_ready: got %b want 01", host_a_ready); end
      checks++; if (host_d_valid !== 2'b01) begin errors++; $display("FAIL sim_d_valid: got %b want 01", host_d_valid); end
      @(negedge clk_in);
      d_valid_in = 1'b0;
      #1;
      checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL sim_net_outstanding: got %0d want 3", outstanding); end
      checks++; if (a_source_out !== 2'd2) begin errors++; $display("FAIL sim_reuse_tag: got %0d want 2", a_source_out); end
      host_a_valid = '0;
   endtask

   task automatic test_unknown_tag();
      do_reset();
      d_valid_in = 1'b1; d_source_in = 2'd3; host_d_ready = 2'b00;
      #1;
      checks++; if (d_ready_in !== 1'b1) begin errors++; $display("FAIL unk_d_ready: got %0b want 1", d_ready_in); end
      checks++; if (host_d_valid !== 2'b00) begin errors++; $display("FAIL unk_d_valid: got %b want 00", host_d_valid); end
      checks++; if (err_unknown_tag !== 1'b1) begin errors++; $display("FAIL unk_err_on: got %0b want 1", err_unknown_tag); end
      @(negedge clk_in);
      d_valid_in = 1'b0;
      #1;
      checks++; if (err_unknown_tag !== 1'b0) begin errors++; $display("FAIL unk_err_off: got %0b want 0", err_unknown_tag); end
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL unk_outstanding: got %0d want 0", outstanding); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_host(0, TL_OP_GET, 1'b1, 32'h0000_0500);
      a_ready_out = 1'b1;
      repeat (3) @(negedge clk_in);
      #1;
      checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL mid_outstanding3: got %0d want 3", outstanding); end
      #1;
      reset_n = 1'b0;
      #1;
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL mid_async_clear: got %0d want 0", outstanding); end
      checks++; if (a_valid_out !== 1'b0) begin errors++; $display("FAIL mid_a_valid: got %0b want 0", a_valid_out); end
      @(negedge clk_in);
      reset_n = 1'b1;
      #1;
      checks++; if (a_source_out !== 2'd0) begin errors++; $display("FAIL mid_first_tag: got %0d want 0", a_source_out); end
      checks++; if (a_valid_out !== 1'b1) begin errors++; $display("FAIL mid_resume_valid: got %0b want 1", a_valid_out); end
      host_a_valid = '0;
      d_valid_in = 1'b1; d_source_in = 2'd1;
      #1;
      checks++; if (err_unknown_tag !== 1'b1) begin errors++; $display("FAIL mid_stale_resp: got %0b want 1", err_unknown_tag); end
      d_valid_in = 1'b0;
   endtask

   initial begin
      do_reset();
      test_reset();
      test_single_get();
      test_round_robin();
      test_lock();
      test_simultaneous();
      test_unknown_tag();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tilelink_cdc_arbiter.md
Name: tilelink_cdc_arbiter

Overview:
- Shares one tilelink_cdc_adapter request port (Channel A, 100 MHz side) among N_HOSTS TileLink hosts and routes Channel D responses back to the issuing host.
- Arbitrates A with round-robin, and remaps each host's source into a free downstream tag from a pool of 2^SRC_WIDTH.
- Tracks outstanding transactions in a tag table; frees the tag on the D handshake.
- Sits between the xbar_main host ports and the adapter's a_*_in / d_*_out ports.

Parameters:
- N_HOSTS, 2, number of requesting hosts (2..4)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- MASK_WIDTH, DATA_WIDTH/8, byte-mask width
- SIZE_WIDTH, 3; OPCODE_WIDTH, 3; PARAM_WIDTH, 3; SINK_WIDTH, 1: field widths matching the adapter
- SRC_WIDTH, 2, downstream tag width; max outstanding = 2^SRC_WIDTH
- HOST_SRC_WIDTH, 1, per-host source width

Ports:
- clk_in  in  1  100 MHz clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- host_a_valid, host_a_ready  in/out  N_HOSTS  per-host A handshake
- host_a_opcode/param/size/source/address/mask/data  in  N_HOSTS*field width each  per-host A fields, packed, host 0 in LSBs
- a_valid_out  out  1;  a_ready_out  in  1  A handshake to the adapter
- a_opcode/param/size/address/mask/data_out  out  field widths  granted host's fields
- a_source_out  out  SRC_WIDTH  allocated tag
- d_valid_in  in  1;  d_ready_in  out  1  D handshake from the adapter
- d_opcode/param/size/sink/data/error_in  in  field widths;  d_source_in  in  SRC_WIDTH  tag
- host_d_valid, host_d_ready  out/in  N_HOSTS  per-host D handshake
- host_d_opcode/param/size/sink/data/error  out  field widths (shared bus, broadcast to all hosts)
- host_d_source  out  HOST_SRC_WIDTH  restored original source
- outstanding  out  SRC_WIDTH+1  count of valid tag-table entries
- err_unknown_tag  out  1  one-cycle pulse on a D beat whose tag entry is invalid

Behaviour:
- Reset (async assert, sync release): tag table all invalid, rr_ptr=0, state IDLE, outstanding=0, err_unknown_tag=0. All valid/ready outputs are 0 while reset_n=0.
- Tag table: 2^SRC_WIDTH entries of {valid, host_idx, orig_src}.
- free_tag = lowest-index invalid entry, computed from registered state only. There is no same-cycle bypass of a free.
- FSM IDLE:
  - If any host_a_valid and a free tag exists, grant the first requesting host at or after rr_ptr (wrapping).
  - Drive a_valid_out=1 combinationally with that host's fields and a_source_out=free_tag.
  - If a_ready_out=1: handshake.
  - Else: register grant and tag, go LOCKED.
- FSM LOCKED:
  - Grant and tag are frozen; a_valid_out stays 1 and fields pass through from the locked host.
  - No re-arbitration until a_ready_out=1, then back to IDLE.
  - Hosts must hold valid and fields stable, per TileLink.
- host_a_ready[i] = a_ready_out && (granted == i) && a_valid_out. It is 0 for every other host.
- No free tag in IDLE: a_valid_out=0 and all host_a_ready=0.
- On A handshake:
  - entry[tag] <= {1, host, host_a_source}.
  - rr_ptr <= granted+1, wrapping at N_HOSTS.
  - outstanding increments.
- D path (combinational, 0 latency):
  - e = entry[d_source_in].
  - If e.valid: host_d_valid[e.host_idx] = d_valid_in and d_ready_in = host_d_ready[e.host_idx].
  - host_d_source = e.orig_src; all other D fields pass through unchanged.
  - On D handshake: entry invalidated, outstanding decrements.
- Unknown tag (d_valid_in with e.valid=0): d_ready_in=1 (beat dropped), no host_d_valid, err_unknown_tag=1 for that cycle.
- Simultaneous A alloc and D free in one cycle:
  - Both table updates apply; outstanding is net unchanged.
  - The allocated tag never equals the freed tag, since free_tag is chosen from pre-free state.
- Counter width SRC_WIDTH+1 so it holds 2^SRC_WIDTH; it never over- or underflows under legal traffic.
- Reset mid-transaction: table cleared immediately. Responses arriving afterwards flag err_unknown_tag.

Decomposition:
- Package tilelink_cdc_pkg:
  - TileLink opcode constants (Get=4, PutFullData=0, PutPartialData=1, AccessAck=0, AccessAckData=1).
  - tag_entry_t struct.
  - Default width localparams shared with tilelink_cdc_adapter.
- Sub-module tilelink_rr_arbiter: N-way round-robin with pointer and lock input. Used for the A grant; reusable by xbar_main.

Test Plan:
- Single Get from host0 with source=1, a_ready_out=1 → same-cycle a_valid_out with a_source_out=0. A D response on tag 0 returns on host_d_valid[0] with host_d_source=1; outstanding goes 0→1→0.
- Both hosts valid continuously, a_ready_out=1 → grants alternate 0,1,0,1; tags 0,1,2,3 allocated; fifth request stalls (a_valid_out=0) until a D beat frees a tag.
- host1 granted with a_ready_out=0 for 3 cycles while host0 also asserts valid → a_valid_out held, fields and tag frozen, host_a_ready[0]=0 throughout; handshake occurs on the 4th cycle.
- With tag 2 outstanding, a D on tag 2 and a new A arrive in the same cycle → tag 2 freed, new A takes the lowest other free tag, outstanding unchanged.
- D beat with d_source_in=3 while entry 3 is invalid → d_ready_in=1, no host_d_valid, err_unknown_tag pulses for 1 cycle.
- reset_n asserted with 3 outstanding → outstanding=0 and a_valid_out=0 asynchronously; after release, the first request gets tag 0.
